sr_latch_bank: RTL and testbench

Parametrised, clocked successor to the single SR latch cell. Provides CHANNELS independent set/reset state bits with per-input debounce filtering and a selectable conflict-resolution mode. Emits one-cycle rise/fall event pulses. Used in the magnetron control path to hold enables such as start/stop, door interlock and timer-done, where raw inputs come from buttons or sensors.

---
 rtl/sr_latch_bank.sv | 178 +++++++++++++++++
 tb/tb_sr_latch_bank.sv | 431 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_bank.sv
// sr_latch_bank: bank of clocked set/reset state bits.
//
// Each channel debounces its raw s and r requests (DEBOUNCE consecutive
// high samples before the request is believed), resolves simultaneous
// set and reset according to PRIORITY, and emits one-cycle rise/fall
// pulses when the held state changes.
//
// Optional build macro: SR_LATCH_BANK_CONFLICT_FLAG_EN
//   When defined, a sticky per-channel 'conflict' output records that the
//   filtered set and reset were ever active together. It is cleared only
//   by reset or clr.
//
// Conflict modes (PRIORITY):
//   0 reset wins, 1 set wins, 2 hold current state, 3 toggle every cycle.

module sr_latch_bank #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned DEBOUNCE = 3,
  parameter int unsigned PRIORITY = 0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] s,
  input  logic [CHANNELS-1:0] r,
  input  logic                clr,
  output logic [CHANNELS-1:0] out,
  output logic [CHANNELS-1:0] rise,
  output logic [CHANNELS-1:0] fall
`ifdef SR_LATCH_BANK_CONFLICT_FLAG_EN
  ,
  output logic [CHANNELS-1:0] conflict
`endif
);

  // Counter wide enough to hold the value DEBOUNCE itself.
  localparam int unsigned CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  // Debounce counters, one per input per channel.
  logic [CHANNELS-1:0][CW-1:0] s_cnt_q, s_cnt_d;
  logic [CHANNELS-1:0][CW-1:0] r_cnt_q, r_cnt_d;

  // Filtered requests derived from the current counter values.
  logic [CHANNELS-1:0] s_eff;
  logic [CHANNELS-1:0] r_eff;

  // Latch state and its edge pulses.
  logic [CHANNELS-1:0] out_q, out_d;
  logic [CHANNELS-1:0] rise_q, rise_d;
  logic [CHANNELS-1:0] fall_q, fall_d;

`ifdef SR_LATCH_BANK_CONFLICT_FLAG_EN
  logic [CHANNELS-1:0] conflict_q, conflict_d;
`endif

  // A high sample advances the count and saturates; any low sample
  // restarts filtering immediately, so release is never debounced.
  function automatic logic [CW-1:0] cnt_next(input logic raw,
                                             input logic [CW-1:0] cnt);
    logic [CW-1:0] nxt;
    if (!raw) begin
      nxt = '0;
    end else if (cnt == CNT_MAX) begin
      nxt = cnt;
    end else begin
      nxt = cnt + CW'(1);
    end
    return nxt;
  endfunction

  // Next latch value from the filtered requests and the current state.
  function automatic logic resolve(input logic set_req,
                                   input logic rst_req,
                                   input logic cur);
    logic nxt;
    case ({set_req, rst_req})
      2'b10:   nxt = 1'b1;
      2'b01:   nxt = 1'b0;
      2'b11: begin
        case (PRIORITY)
          32'd0:   nxt = 1'b0;
          32'd1:   nxt = 1'b1;
          32'd2:   nxt = cur;
          32'd3:   nxt = ~cur;
          default: nxt = 1'b0;
        endcase
      end
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Filtered flags: a request is believed once its counter has saturated.
  always_comb begin
    s_eff = '0;
    r_eff = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      s_eff[i] = (s_cnt_q[i] == CNT_MAX);
      r_eff[i] = (r_cnt_q[i] == CNT_MAX);
    end
  end

  // Debounce counter next state; clr restarts every filter from zero.
  always_comb begin
    s_cnt_d = s_cnt_q;
    r_cnt_d = r_cnt_q;
    if (clr) begin
      s_cnt_d = '0;
      r_cnt_d = '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        s_cnt_d[i] = cnt_next(s[i], s_cnt_q[i]);
        r_cnt_d[i] = cnt_next(r[i], r_cnt_q[i]);
      end
    end
  end

  // Latch next state and edge pulses; clr zeroes state without a fall pulse.
  always_comb begin
    out_d  = out_q;
    rise_d = '0;
    fall_d = '0;
    if (clr) begin
      out_d  = '0;
      rise_d = '0;
      fall_d = '0;
    end else begin
      for (int i = 0; i < int'(CHANNELS); i++) begin
        out_d[i] = resolve(s_eff[i], r_eff[i], out_q[i]);
      end
      rise_d = out_d & ~out_q;
      fall_d = ~out_d & out_q;
    end
  end

`ifdef SR_LATCH_BANK_CONFLICT_FLAG_EN
  // Sticky record of any cycle where set and reset were both believed.
  always_comb begin
    conflict_d = conflict_q;
    if (clr) begin
      conflict_d = '0;
    end else begin
      conflict_d = conflict_q | (s_eff & r_eff);
    end
  end
`endif

  // State registers: reset clears everything at once, even mid-debounce.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s_cnt_q    <= '0;
      r_cnt_q    <= '0;
      out_q      <= '0;
      rise_q     <= '0;
      fall_q     <= '0;
`ifdef SR_LATCH_BANK_CONFLICT_FLAG_EN
      conflict_q <= '0;
`endif
    end else begin
      s_cnt_q    <= s_cnt_d;
      r_cnt_q    <= r_cnt_d;
      out_q      <= out_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
`ifdef SR_LATCH_BANK_CONFLICT_FLAG_EN
      conflict_q <= conflict_d;
`endif
    end
  end

  assign out  = out_q;
  assign rise = rise_q;
  assign fall = fall_q;
`ifdef SR_LATCH_BANK_CONFLICT_FLAG_EN
  assign conflict = conflict_q;
`endif

endmodule

// File: tb/tb_sr_latch_bank.sv
// Bench for sr_latch_bank: four instances (PRIORITY 0..3) share the same
// stimulus. A behavioural model predicts each cycle's outputs and pushes
// them to a scoreboard queue; each test task pops and compares after the
// edge, plus directed checks on the scenario's key cycles.

module tb_sr_latch_bank;

  localparam int DEB = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] s;
  logic [3:0] r;
  logic       clr;
  logic [3:0] out_p  [4];
  logic [3:0] rise_p [4];
  logic [3:0] fall_p [4];
  logic [3:0] conf_p [4];

  always #5 clk = ~clk;

  for (genvar p = 0; p < 4; p++) begin : g_dut
    sr_latch_bank #(.CHANNELS(4), .DEBOUNCE(DEB), .PRIORITY(p)) u_dut (
      .clk      (clk),
      .reset    (reset),
      .s        (s),
      .r        (r),
      .clr      (clr),
      .out      (out_p[p]),
      .rise     (rise_p[p]),
`ifdef SR_LATCH_BANK_CONFLICT_FLAG_EN
      .fall     (fall_p[p]),
      .conflict (conf_p[p])
`else
      .fall     (fall_p[p])
`endif
    );
`ifndef SR_LATCH_BANK_CONFLICT_FLAG_EN
    assign conf_p[p] = 4'b0000;
`endif
  end

  typedef struct packed {
    logic [15:0] o;
    logic [15:0] ri;
    logic [15:0] fa;
    logic [15:0] cf;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;

  // Reference model state
  int         m_scnt [4];
  int         m_rcnt [4];
  logic [3:0] m_out  [4];
  logic [3:0] m_conf;

  task automatic model_reset();
    for (int ch = 0; ch < 4; ch++) begin
      m_scnt[ch] = 0;
      m_rcnt[ch] = 0;
    end
    for (int p = 0; p < 4; p++) m_out[p] = 4'b0000;
    m_conf = 4'b0000;
  endtask

  // Predict the outputs after one clock edge with the given inputs.
  task automatic model_edge(input logic [3:0] sv, input logic [3:0] rv, input logic cv);
    exp_t       e;
    logic [3:0] se;
    logic [3:0] re;
    logic [3:0] prev;
    e = '0;
    for (int ch = 0; ch < 4; ch++) begin
      se[ch] = (m_scnt[ch] == DEB);
      re[ch] = (m_rcnt[ch] == DEB);
    end
    for (int p = 0; p < 4; p++) begin
      prev = m_out[p];
      if (cv) begin
        m_out[p] = 4'b0000;
      end else begin
        for (int ch = 0; ch < 4; ch++) begin
          if (se[ch] && !re[ch]) m_out[p][ch] = 1'b1;
          else if (!se[ch] && re[ch]) m_out[p][ch] = 1'b0;
          else if (se[ch] && re[ch]) begin
            if (p == 0) m_out[p][ch] = 1'b0;
            else if (p == 1) m_out[p][ch] = 1'b1;
            else if (p == 3) m_out[p][ch] = ~prev[ch];
          end
        end
      end
      e.o[p*4 +: 4] = m_out[p];
      if (!cv) begin
        e.ri[p*4 +: 4] = m_out[p] & ~prev;
        e.fa[p*4 +: 4] = ~m_out[p] & prev;
      end
    end
    if (cv) m_conf = 4'b0000;
    else    m_conf = m_conf | (se & re);
    for (int ch = 0; ch < 4; ch++) begin
      if (cv) begin
        m_scnt[ch] = 0;
        m_rcnt[ch] = 0;
      end else begin
        m_scnt[ch] = sv[ch] ? ((m_scnt[ch] < DEB) ? m_scnt[ch] + 1 : DEB) : 0;
        m_rcnt[ch] = rv[ch] ? ((m_rcnt[ch] < DEB) ? m_rcnt[ch] + 1 : DEB) : 0;
      end
    end
`ifdef SR_LATCH_BANK_CONFLICT_FLAG_EN
    e.cf = {4{m_conf}};
`endif
    exp_q.push_back(e);
  endtask

  function automatic exp_t sample();
    exp_t o;
    o = '0;
    for (int p = 0; p < 4; p++) begin
      o.o[p*4 +: 4]  = out_p[p];
      o.ri[p*4 +: 4] = rise_p[p];
      o.fa[p*4 +: 4] = fall_p[p];
      o.cf[p*4 +: 4] = conf_p[p];
    end
    return o;
  endfunction

  // Drive one cycle of stimulus, record the prediction, advance past the edge.
  task automatic cycle(input logic [3:0] sv, input logic [3:0] rv, input logic cv);
    s   = sv;
    r   = rv;
    clr = cv;
    model_edge(sv, rv, cv);
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    s     = 4'b0000;
    r     = 4'b0000;
    clr   = 1'b0;
    reset = 1'b1;
    model_reset();
    #3;
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t o;
    s     = 4'b1111;
    r     = 4'b0000;
    clr   = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_hold: got %h expected 0", o);
    end
    apply_reset();
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL reset_release: got %h expected 0", o);
    end
  endtask

  task automatic test_set_latency();
    exp_t e;
    exp_t o;
    apply_reset();
    for (int k = 1; k <= 6; k++) begin
      cycle(4'b0001, 4'b0000, 1'b0);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sb_set edge %0d: got %h expected %h", k, o, e);
      end
      checks++;
      if (k == 3 && out_p[0] !== 4'b0000) begin
        errors++;
        $display("FAIL set_early edge 3: got out=%b expected 0000", out_p[0]);
      end else if (k == 4 && (out_p[0] !== 4'b0001 || rise_p[0] !== 4'b0001)) begin
        errors++;
        $display("FAIL set_edge4: got out=%b rise=%b expected 0001/0001", out_p[0], rise_p[0]);
      end else if (k == 5 && (out_p[0] !== 4'b0001 || rise_p[0] !== 4'b0000)) begin
        errors++;
        $display("FAIL set_edge5: got out=%b rise=%b expected 0001/0000", out_p[0], rise_p[0]);
      end
    end
  endtask

  task automatic test_glitch();
    exp_t e;
    exp_t o;
    logic [7:0] pat;
    pat = 8'b0011011;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      cycle({2'b00, pat[k], 1'b0}, 4'b0000, 1'b0);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sb_glitch cycle %0d: got %h expected %h", k, o, e);
      end
      checks++;
      if (out_p[0][1] !== 1'b0 || rise_p[0][1] !== 1'b0) begin
        errors++;
        $display("FAIL glitch cycle %0d: got out1=%b rise1=%b expected 0/0", k, out_p[0][1], rise_p[0][1]);
      end
    end
  endtask

  task automatic test_conflict();
    exp_t e;
    exp_t o;
    int   nr [4];
    int   nf [4];
    logic [3:0] sv;
    logic [3:0] rv;
    apply_reset();
    for (int p = 0; p < 4; p++) begin
      nr[p] = 0;
      nf[p] = 0;
    end
    // 4 cycles set only, 6 cycles both, 3 cycles idle
    for (int k = 0; k < 13; k++) begin
      sv = (k < 10) ? 4'b0100 : 4'b0000;
      rv = (k >= 4 && k < 10) ? 4'b0100 : 4'b0000;
      cycle(sv, rv, 1'b0);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sb_conflict cycle %0d: got %h expected %h", k, o, e);
      end
      if (k >= 4) begin
        for (int p = 0; p < 4; p++) begin
          nr[p] += int'(rise_p[p][2]);
          nf[p] += int'(fall_p[p][2]);
        end
      end
    end
    checks++;
    if (out_p[0][2] !== 1'b0 || nf[0] != 1 || nr[0] != 0) begin
      errors++;
      $display("FAIL conflict_p0: got out=%b falls=%0d rises=%0d expected 0/1/0", out_p[0][2], nf[0], nr[0]);
    end
    checks++;
    if (out_p[1][2] !== 1'b1 || nf[1] != 0 || nr[1] != 0) begin
      errors++;
      $display("FAIL conflict_p1: got out=%b falls=%0d rises=%0d expected 1/0/0", out_p[1][2], nf[1], nr[1]);
    end
    checks++;
    if (out_p[2][2] !== 1'b1 || nf[2] != 0 || nr[2] != 0) begin
      errors++;
      $display("FAIL conflict_p2: got out=%b falls=%0d rises=%0d expected 1/0/0", out_p[2][2], nf[2], nr[2]);
    end
    checks++;
    if (out_p[3][2] !== 1'b1 || nf[3] != 2 || nr[3] != 2) begin
      errors++;
      $display("FAIL conflict_p3: got out=%b falls=%0d rises=%0d expected 1/2/2", out_p[3][2], nf[3], nr[3]);
    end
`ifdef SR_LATCH_BANK_CONFLICT_FLAG_EN
    checks++;
    if (conf_p[0] !== 4'b0100) begin
      errors++;
      $display("FAIL conflict_flag_sticky: got %b expected 0100", conf_p[0]);
    end
    cycle(4'b0000, 4'b0000, 1'b1);
    e = exp_q.pop_front();
    o = sample();
    checks++;
    if (o !== e || conf_p[0] !== 4'b0000) begin
      errors++;
      $display("FAIL conflict_flag_clr: got %h flag=%b expected %h flag=0000", o, conf_p[0], e);
    end
`endif
  endtask

  task automatic test_clear();
    exp_t e;
    exp_t o;
    apply_reset();
    for (int k = 0; k < 4; k++) begin
      cycle(4'b1111, 4'b0000, 1'b0);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sb_clear_fill cycle %0d: got %h expected %h", k, o, e);
      end
    end
    cycle(4'b1111, 4'b0000, 1'b1);
    e = exp_q.pop_front();
    o = sample();
    checks++;
    if (o !== e || out_p[0] !== 4'b0000 || fall_p[0] !== 4'b0000 || fall_p[3] !== 4'b0000) begin
      errors++;
      $display("FAIL clear_edge: got %h expected %h", o, e);
    end
    // First sample after clr is edge 1; state returns DEBOUNCE edges after that.
    for (int k = 1; k <= 5; k++) begin
      cycle(4'b1111, 4'b0000, 1'b0);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sb_clear edge %0d: got %h expected %h", k, o, e);
      end
      checks++;
      if (k == 3 && out_p[1] !== 4'b0000) begin
        errors++;
        $display("FAIL clear_early edge 3: got out=%b expected 0000", out_p[1]);
      end else if (k == 4 && (out_p[1] !== 4'b1111 || rise_p[1] !== 4'b1111)) begin
        errors++;
        $display("FAIL clear_return edge 4: got out=%b rise=%b expected 1111/1111", out_p[1], rise_p[1]);
      end else if (k == 5 && rise_p[1] !== 4'b0000) begin
        errors++;
        $display("FAIL clear_rise_once: got rise=%b expected 0000", rise_p[1]);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t e;
    exp_t o;
    apply_reset();
    for (int k = 0; k < 6; k++) begin
      cycle((k < 4) ? 4'b0001 : 4'b1001, 4'b0000, 1'b0);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sb_areset_pre cycle %0d: got %h expected %h", k, o, e);
      end
    end
    reset = 1'b1;
    #1;
    o = sample();
    checks++;
    if (o !== '0) begin
      errors++;
      $display("FAIL areset_immediate: got %h expected 0", o);
    end
    model_reset();
    #1;
    reset = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cycle(4'b1000, 4'b0000, 1'b0);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sb_areset edge %0d: got %h expected %h", k, o, e);
      end
      checks++;
      if (k == 3 && out_p[2][3] !== 1'b0) begin
        errors++;
        $display("FAIL areset_fresh edge 3: got out3=%b expected 0", out_p[2][3]);
      end else if (k == 4 && out_p[2][3] !== 1'b1) begin
        errors++;
        $display("FAIL areset_set edge 4: got out3=%b expected 1", out_p[2][3]);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t o;
    logic [3:0] sv;
    logic [3:0] rv;
    logic       cv;
    apply_reset();
    for (int k = 0; k < 300; k++) begin
      sv = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      rv = 4'($urandom_range(0, 15)) | 4'($urandom_range(0, 15));
      cv = ($urandom_range(0, 39) == 0);
      cycle(sv, rv, cv);
      e = exp_q.pop_front();
      o = sample();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL sb_random cycle %0d: got %h expected %h", k, o, e);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    s     = 4'b0000;
    r     = 4'b0000;
    clr   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_set_latency();
    test_glitch();
    test_conflict();
    test_clear();
    test_async_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
